// File: rtl/rooth_mem_arb.sv
// Three-master arbiter for the rooth unified single-port RAM.
// M0 strict priority, M1/M2 round-robin, timed bus lock for bursts.
module rooth_mem_arb #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req_i,
    input  logic [2:0]          lock_i,
    input  logic [2:0]          we_i,
    input  logic [3*AW-1:0]     addr_i,
    input  logic [3*DW-1:0]     wdata_i,
    input  logic [3*DW/8-1:0]   be_i,
    output logic [2:0]          gnt_o,
    output logic [2:0]          rvalid_o,
    output logic [DW-1:0]       rdata_o,
    output logic                hold_o,
    output logic                lock_err_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_wdata_o,
    output logic [DW/8-1:0]     mem_be_o,
    input  logic [DW-1:0]       mem_rdata_i
);

    localparam int BW = DW / 8;
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;
    logic [2:0]     owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     blk_q, blk_d;
    logic           err_q, err_d;
    logic [2:0]     rvalid_q;
    logic [2:0]     gnt;

    // rr_q: 0 favours M1, 1 favours M2; owner is one-hot, 0 = none
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_q     <= 1'b0;
            owner_q  <= 3'b000;
            cnt_q    <= '0;
            blk_q    <= 3'b000;
            err_q    <= 1'b0;
            rvalid_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            blk_q    <= blk_d;
            err_q    <= err_d;
            rvalid_q <= gnt & ~we_i;
        end
    end

    always_comb begin
        gnt     = 3'b000;
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q & lock_i;
        err_d   = 1'b0;
        unique case (state_q)
            ARB: begin
                unique case (1'b1)
                    req_i[0]:
                        gnt = 3'b001;
                    !req_i[0] && req_i[1] && (!req_i[2] || !rr_q):
                        gnt = 3'b010;
                    !req_i[0] && req_i[2] && (!req_i[1] || rr_q):
                        gnt = 3'b100;
                    default:
                        gnt = 3'b000;
                endcase
                if (gnt[1]) rr_d = 1'b1;
                if (gnt[2]) rr_d = 1'b0;
                if (|(gnt & lock_i & ~blk_q)) begin
                    state_d = LOCKED;
                    owner_d = gnt;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                gnt   = req_i & owner_q;
                cnt_d = cnt_q + CW'(1);
                if (!(|(lock_i & owner_q))) begin
                    state_d = ARB;
                    owner_d = 3'b000;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // timeout: owner may still arbitrate but not re-lock
                    state_d = ARB;
                    owner_d = 3'b000;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    blk_d   = blk_d | owner_q;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int k = 0; k < 3; k++) begin
            if (gnt[k]) begin
                mem_addr_o  = addr_i[k*AW +: AW];
                mem_wdata_o = wdata_i[k*DW +: DW];
                mem_be_o    = be_i[k*BW +: BW];
            end
        end
    end

    assign gnt_o      = gnt;
    assign mem_ce_o   = |gnt;
    assign mem_we_o   = |(gnt & we_i);
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = (|rvalid_q) ? mem_rdata_i : '0;
    assign lock_err_o = err_q;
    assign hold_o     = (req_i[1] & ~gnt[1]) | (req_i[2] & ~gnt[2]);

endmodule

// File: tb/tb_rooth_mem_arb.sv
// Directed bench for rooth_mem_arb with a behavioural byte-enabled RAM.
// Words init to 0xCAFE0000 | word_index while reset is low.
module tb_rooth_mem_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req, lock, we;
    logic [95:0]  addr, wdata;
    logic [11:0]  be;
    logic [2:0]   gnt, rvalid;
    logic [31:0]  rdata;
    logic         hold, lock_err;
    logic         mem_ce, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_be;
    logic [31:0]  mem_rdata;

    logic [31:0]  ram [256];
    int           checks = 0;
    int           errors = 0;
    int           bad, pulses, badhold;
    logic [2:0]   exp_g;

    always #5 clk = ~clk;

    rooth_mem_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .hold_o      (hold),
        .lock_err_o  (lock_err),
        .mem_ce_o    (mem_ce),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hCAFE0000 | 32'(i);
            mem_rdata <= 32'h0;
        end else if (mem_ce) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fld(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
        addr[k*32 +: 32]  = a;
        wdata[k*32 +: 32] = d;
        be[k*4 +: 4]      = b;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; lock = '0; we = '0;
        addr = '0; wdata = '0; be = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_lock_err", 32'(lock_err), 32'h0);
        chk("rst_mem_ce", 32'(mem_ce), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // round-robin reads M1 (0x0) / M2 (0x4)
        next_cycle;
        fld(1, 32'h0, 32'h0, 4'h0);
        fld(2, 32'h4, 32'h0, 4'h0);
        req = 3'b110;
        settle;
        chk("t1_gnt0", 32'(gnt), 32'h2);
        chk("t1_hold0", 32'(hold), 32'h1);
        next_cycle; settle;
        chk("t1_gnt1", 32'(gnt), 32'h4);
        chk("t1_rv1", 32'(rvalid), 32'h2);
        chk("t1_rd1", rdata, 32'hCAFE0000);
        next_cycle; settle;
        chk("t1_gnt2", 32'(gnt), 32'h2);
        chk("t1_rv2", 32'(rvalid), 32'h4);
        chk("t1_rd2", rdata, 32'hCAFE0001);
        next_cycle; settle;
        chk("t1_gnt3", 32'(gnt), 32'h4);
        chk("t1_rv3", 32'(rvalid), 32'h2);
        next_cycle;
        req = 3'b000;
        settle;
        chk("t1_rv4", 32'(rvalid), 32'h4);
        chk("t1_rd4", rdata, 32'hCAFE0001);
        next_cycle; settle;
        chk("t1_idle_rv", 32'(rvalid), 32'h0);
        chk("t1_idle_rd", rdata, 32'h0);

        // M1 locked write burst, M0 waits from burst cycle 2
        for (int i = 0; i < 8; i++) begin
            next_cycle;
            req[1] = 1'b1; we[1] = 1'b1;
            lock[1] = (i < 7);
            fld(1, 32'h100 + 32'(4 * i), 32'h10000000 + 32'(i), 4'hF);
            if (i >= 2) begin
                req[0] = 1'b1; we[0] = 1'b0;
                fld(0, 32'h8, 32'h0, 4'h0);
            end
            settle;
            chk("t2_burst_gnt", 32'(gnt), 32'h2);
        end
        next_cycle;
        req[1] = 1'b0; we[1] = 1'b0; lock = 3'b000;
        settle;
        chk("t2_m0_gnt", 32'(gnt), 32'h1);
        next_cycle;
        req[0] = 1'b0;
        settle;
        chk("t2_m0_rv", 32'(rvalid), 32'h1);
        chk("t2_m0_rd", rdata, 32'hCAFE0002);
        for (int i = 0; i < 8; i++)
            chk("t2_ram", ram[64 + i], 32'h10000000 + 32'(i));

        // M2 lock held past LOCK_MAX, M1 pending
        next_cycle;
        req = 3'b100; lock = 3'b100; we = 3'b000;
        fld(2, 32'hC, 32'h0, 4'h0);
        fld(1, 32'h14, 32'h0, 4'h0);
        settle;
        chk("t3_start_gnt", 32'(gnt), 32'h4);
        bad = 0; pulses = 0; badhold = 0;
        for (int i = 1; i <= 64; i++) begin
            next_cycle;
            req = 3'b110;
            settle;
            if (gnt !== 3'b100) bad++;
            if (lock_err) pulses++;
            if (hold !== 1'b1) badhold++;
        end
        chk("t3_locked_gnt", 32'(bad), 32'h0);
        chk("t3_early_err", 32'(pulses), 32'h0);
        chk("t3_locked_hold", 32'(badhold), 32'h0);
        next_cycle; settle;
        chk("t3_err_pulse", 32'(lock_err), 32'h1);
        chk("t3_m1_after", 32'(gnt), 32'h2);
        bad = 0; pulses = 0;
        for (int i = 66; i < 100; i++) begin
            next_cycle; settle;
            exp_g = (i % 2 == 0) ? 3'b100 : 3'b010;
            if (gnt !== exp_g) bad++;
            if (lock_err) pulses++;
        end
        chk("t3_no_relock", 32'(bad), 32'h0);
        chk("t3_one_pulse", 32'(pulses), 32'h0);
        next_cycle;
        req = 3'b000; lock = 3'b000;
        settle;
        next_cycle;
        req = 3'b100; lock = 3'b100;
        settle;
        chk("t3_relock_gnt", 32'(gnt), 32'h4);
        next_cycle;
        req = 3'b110;
        settle;
        chk("t3_relocked", 32'(gnt), 32'h4);
        next_cycle;
        lock = 3'b000;
        settle;
        chk("t3_unlock_cyc", 32'(gnt), 32'h4);
        next_cycle;
        req = 3'b010;
        settle;
        chk("t3_back_arb", 32'(gnt), 32'h2);

        // all three read 0x0/0x4/0x8; lone M2 read first points rr at M1
        next_cycle;
        req = 3'b100;
        fld(2, 32'h8, 32'h0, 4'h0);
        settle;
        next_cycle;
        req = 3'b111;
        fld(0, 32'h0, 32'h0, 4'h0);
        fld(1, 32'h4, 32'h0, 4'h0);
        settle;
        chk("t4_gnt0", 32'(gnt), 32'h1);
        chk("t4_hold0", 32'(hold), 32'h1);
        next_cycle;
        req = 3'b110;
        settle;
        chk("t4_gnt1", 32'(gnt), 32'h2);
        chk("t4_hold1", 32'(hold), 32'h1);
        chk("t4_addr1", mem_addr, 32'h4);
        chk("t4_rv1", 32'(rvalid), 32'h1);
        chk("t4_rd1", rdata, 32'hCAFE0000);
        next_cycle;
        req = 3'b100;
        settle;
        chk("t4_gnt2", 32'(gnt), 32'h4);
        chk("t4_hold2", 32'(hold), 32'h0);
        chk("t4_rd2", rdata, 32'hCAFE0001);
        next_cycle;
        req = 3'b000;
        settle;
        chk("t4_rv3", 32'(rvalid), 32'h4);
        chk("t4_rd3", rdata, 32'hCAFE0002);

        // partial write then read back
        next_cycle;
        req = 3'b010; we = 3'b010;
        fld(1, 32'h40, 32'hDEADBEEF, 4'b0011);
        settle;
        chk("t5_wgnt", 32'(gnt), 32'h2);
        chk("t5_mem_we", 32'(mem_we), 32'h1);
        chk("t5_mem_be", 32'(mem_be), 32'h3);
        chk("t5_mem_wd", mem_wdata, 32'hDEADBEEF);
        next_cycle;
        req = 3'b100; we = 3'b000;
        fld(2, 32'h40, 32'h0, 4'h0);
        settle;
        chk("t5_rgnt", 32'(gnt), 32'h4);
        next_cycle;
        req = 3'b000;
        settle;
        chk("t5_rv", 32'(rvalid), 32'h4);
        chk("t5_rd", rdata, 32'hCAFEBEEF);

        // reset while LOCKED with a read in flight
        next_cycle;
        req = 3'b010; lock = 3'b010;
        fld(1, 32'h0, 32'h0, 4'h0);
        settle;
        chk("t6_lock_gnt", 32'(gnt), 32'h2);
        next_cycle;
        fld(1, 32'h4, 32'h0, 4'h0);
        settle;
        chk("t6_locked_rv", 32'(rvalid), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rv", 32'(rvalid), 32'h0);
        chk("t6_rst_rd", rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req = 3'b000; lock = 3'b000;
        rst_n = 1'b1;
        next_cycle; settle;
        chk("t6_dropped_rv", 32'(rvalid), 32'h0);
        next_cycle;
        req = 3'b110;
        settle;
        chk("t6_rr_gnt", 32'(gnt), 32'h2);
        chk("t6_no_err", 32'(lock_err), 32'h0);
        next_cycle;
        req = 3'b000;
        settle;
        chk("t6_rv_after", 32'(rvalid), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
